uart_tx: RTL and testbench

Serial transmitter for the 8051 core's UART: accepts a byte from the SBUF write path and shifts it out on `txd` as an asynchronous frame (start bit, 8 data bits LSB first, optional parity, stop bit). It runs on the same 16x-oversampled `clk_uart` as `UartIf`, so its `txd` connects directly to the receiver's `rxd` for loopback. It produces the next-state value of the TI flag in the same way `UartIf` produces the RI flag.

---
 rtl/uart_tx_if.sv | 28 ++
 rtl/uart_tx.sv | 121 ++++++++++++
 tb/tb_uart_tx.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// SBUF-side bundle for the UART transmitter.
// Driver side is master, transmitter is slave.
interface uart_tx_if;
  logic [7:0] t_data;
  logic       t_start;
  logic       txd_int_in;
  logic       txd;
  logic       txd_int;
  logic       busy;

  modport master (
    output t_data,
    output t_start,
    output txd_int_in,
    input  txd,
    input  txd_int,
    input  busy
  );

  modport slave (
    input  t_data,
    input  t_start,
    input  txd_int_in,
    output txd,
    output txd_int,
    output busy
  );
endinterface

// File: rtl/uart_tx.sv
// 8051 UART transmitter: start, 8 data LSB first, stop.
// Define UART_TX_PARITY_EN to add an even-parity bit.
module uart_tx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic     clk_uart,
  input  logic     rst_n,
  uart_tx_if.slave bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          last;

  assign last = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    if (state_q != S_IDLE) begin
      cnt_d = last ? '0 : cnt_q + CW'(1);
    end
    unique case (state_q)
      S_IDLE: begin
        if (bus.t_start) begin
          state_d = S_START;
          shift_d = bus.t_data;
          par_d   = ^bus.t_data;
          bit_d   = '0;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (last) state_d = S_DATA;
      end
      S_DATA: begin
        if (last) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (last) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level is registered from the next state so txd never glitches.
  always_comb begin
    txd_d  = 1'b1;
    busy_d = (state_d != S_IDLE);
    unique case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = par_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_uart or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.txd     = txd_q;
  assign bus.busy    = busy_q;
  assign bus.txd_int = (state_q == S_STOP && last)
                       ? 1'b1 : bus.txd_int_in;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with a serial receiver model
// and a byte scoreboard.
module tb_uart_tx;

  localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11 * OS;
`else
  localparam int FL = 10 * OS;
`endif

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   ti_count;
  bit   mon_en;
  logic [7:0] sb[$];

  uart_tx_if bus ();

  uart_tx #(.OVERSAMPLE(OS)) dut (
    .clk_uart (clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic exp_txd(input logic [7:0] b,
                                   input int c);
    int k;
    k = (c - 1) / OS;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (bus.txd_int === 1'b1 && bus.txd_int_in === 1'b0)
      ti_count++;
  end

  // Receiver model: samples each bit in its middle.
  initial begin
    forever begin : mon
      logic [7:0] d;
      logic [7:0] e;
      logic       p;
      @(negedge clk);
      if (mon_en && rst_n === 1'b1 && bus.txd === 1'b0) begin
        p = 1'b0;
        repeat (OS / 2 - 1) @(negedge clk);
        check("mon_start", 32'(bus.txd), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (OS) @(negedge clk);
          d[i] = bus.txd;
        end
`ifdef UART_TX_PARITY_EN
        repeat (OS) @(negedge clk);
        p = bus.txd;
`endif
        repeat (OS) @(negedge clk);
        check("mon_stop", 32'(bus.txd), 32'd1);
        e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        check("mon_data", 32'(d), 32'(e));
`ifdef UART_TX_PARITY_EN
        check("mon_parity", 32'(p), 32'(^e));
`endif
      end
    end
  end

  task automatic start_byte(input logic [7:0] b,
                            input bit push);
    @(posedge clk);
    #1;
    bus.t_data  = b;
    bus.t_start = 1'b1;
    if (push) sb.push_back(b);
    @(posedge clk);
    #1;
    bus.t_start = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] b,
                           input int pa,
                           input int pb);
    int busy_cnt;
    int ti_cnt;
    int ti_at;
    logic exp_ti;
    busy_cnt = 0;
    ti_cnt   = 0;
    ti_at    = 0;
    start_byte(b, 1'b1);
    for (int c = 1; c <= FL + OS; c++) begin
      @(negedge clk);
      check($sformatf("txd_%0h_c%0d", b, c),
            32'(bus.txd), 32'(exp_txd(b, c)));
      exp_ti = bus.txd_int_in | (c == FL);
      check($sformatf("ti_%0h_c%0d", b, c),
            32'(bus.txd_int), 32'(exp_ti));
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.txd_int === 1'b1 && bus.txd_int_in === 1'b0) begin
        ti_cnt++;
        ti_at = c;
      end
      if (c == FL + 1)
        check("busy_fall", 32'(bus.busy), 32'd0);
      bus.t_start = (c == pa || c == pb);
      bus.t_data  = bus.t_start ? 8'h00 : b;
    end
    bus.t_start = 1'b0;
    check($sformatf("busy_len_%0h", b), busy_cnt, FL);
    if (bus.txd_int_in === 1'b0) begin
      check($sformatf("ti_cnt_%0h", b), ti_cnt, 1);
      check($sformatf("ti_at_%0h", b), ti_at, FL);
    end
  endtask

  initial begin
    int ti0;
    tests = 0;
    fails = 0;
    ti_count = 0;
    mon_en = 1'b1;
    rst_n = 1'b0;
    bus.t_data = 8'h00;
    bus.t_start = 1'b0;
    bus.txd_int_in = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(bus.txd), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ti0", 32'(bus.txd_int), 32'd0);
    bus.txd_int_in = 1'b1;
    #1;
    check("rst_ti1", 32'(bus.txd_int), 32'd1);
    bus.txd_int_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic frame
    run_frame(8'h5C, 0, 0);

    // Back-to-back loopback
    ti0 = ti_count;
    start_byte(8'hA5, 1'b1);
    for (int c = 1; c <= FL + 1; c++) @(negedge clk);
    check("b2b_gap_txd", 32'(bus.txd), 32'd1);
    check("b2b_gap_busy", 32'(bus.busy), 32'd0);
    bus.t_data  = 8'h3A;
    bus.t_start = 1'b1;
    sb.push_back(8'h3A);
    @(posedge clk);
    #1;
    bus.t_start = 1'b0;
    @(negedge clk);
    check("b2b_start_txd", 32'(bus.txd), 32'd0);
    check("b2b_start_busy", 32'(bus.busy), 32'd1);
    repeat (FL + OS) @(negedge clk);
    check("b2b_ti_pulses", ti_count - ti0, 2);

    // Strobes while busy, including final STOP cycle
    run_frame(8'h0F, 50, FL);

    // Abort by reset mid-frame
    mon_en = 1'b0;
    start_byte(8'hFF, 1'b0);
    repeat (69) @(negedge clk);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    ti0 = ti_count;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_txd", 32'(bus.txd), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_ti", 32'(bus.txd_int), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (FL) @(negedge clk);
    check("post_rst_txd", 32'(bus.txd), 32'd1);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    check("post_rst_no_ti", ti_count - ti0, 0);
    mon_en = 1'b1;
    run_frame(8'h96, 0, 0);

    // TI input held high, then low while idle
    bus.txd_int_in = 1'b1;
    run_frame(8'h42, 0, 0);
    bus.txd_int_in = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("idle_ti0", 32'(bus.txd_int), 32'd0);
    end

`ifdef UART_TX_PARITY_EN
    run_frame(8'h07, 0, 0);
    run_frame(8'h03, 0, 0);
`endif

    repeat (2 * OS) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
